// File: rtl/misr_compactor.sv
// Multiple-input signature register compactor for a two-output circuit under test.
// Folds i/j into a Galois-style LFSR signature for a fixed sample count and checks it against GOLDEN.
module misr_compactor #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] POLY         = 8'h1D,
    parameter int               NUM_PATTERNS = 8,
    parameter logic [WIDTH-1:0] GOLDEN       = 8'hE3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic             in_valid,
    input  logic             i,
    input  logic             j,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [7:0]       count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [7:0] LAST = 8'(NUM_PATTERNS);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;
    logic [WIDTH-1:0] fold;
    logic [7:0]       cnt_q;
    logic [7:0]       cnt_d;
    logic [7:0]       cnt_inc;
    logic             pass_q;
    logic             pass_d;
    logic             busy_q;
    logic             done_q;

    // Shift with feedback, then fold the two response bits into the low end.
    always_comb begin
        fold = {sig_q[WIDTH-2:0], 1'b0}
             ^ (sig_q[WIDTH-1] ? POLY : '0)
             ^ {{(WIDTH-2){1'b0}}, j, i};
    end

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = COMPACT;
                    sig_d   = seed;
                    cnt_d   = 8'd0;
                    pass_d  = 1'b0;
                end
            end
            COMPACT: begin
                if (in_valid) begin
                    sig_d = fold;
                    cnt_d = cnt_inc;
                    if (cnt_inc == LAST) begin
                        state_d = DONE;
                        pass_d  = (fold == GOLDEN);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sig_q   <= '0;
            cnt_q   <= 8'd0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            busy_q  <= (state_d == COMPACT);
            done_q  <= (state_d == DONE);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_q;
    assign count     = cnt_q;

endmodule

// File: tb/tb_misr_compactor.sv
// Scoreboard bench for misr_compactor at default parameters.
// Expected signature/count/done are queued as each sample is driven and compared after the edge.
module tb_misr_compactor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] seed;
    logic       in_valid;
    logic       i;
    logic       j;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] signature;
    logic [7:0] count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] sig;
        logic [7:0] cnt;
        logic       dn;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_sig;
    logic [7:0] m_cnt;
    logic [7:0] golden_steps [8] = '{8'h02, 8'h06, 8'h0E, 8'h1E,
                                     8'h3E, 8'h7E, 8'hFE, 8'hE3};

    misr_compactor dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seed      (seed),
        .in_valid  (in_valid),
        .i         (i),
        .j         (j),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_sig = 8'h00;
        m_cnt = 8'd0;
    endtask

    task automatic begin_session(input logic [7:0] s);
        start = 1'b1;
        seed  = s;
        tick();
        start = 1'b0;
        m_sig = s;
        m_cnt = 8'd0;
        check("start_busy", 16'(busy), 16'd1);
        check("start_done", 16'(done), 16'd0);
        check("start_sig", 16'(signature), 16'(s));
        check("start_cnt", 16'(count), 16'd0);
    endtask

    // Push expectation from the bench model, drive one sample, pop and compare.
    task automatic send(input logic ii, input logic jj);
        exp_t e;
        exp_t g;
        logic fb;
        fb    = m_sig[7];
        m_sig = {m_sig[6:0], 1'b0};
        if (fb) m_sig = m_sig ^ 8'h1D;
        m_sig = m_sig ^ {6'b0, jj, ii};
        m_cnt = m_cnt + 8'd1;
        e.sig = m_sig;
        e.cnt = m_cnt;
        e.dn  = (m_cnt == 8'd8);
        sb.push_back(e);
        in_valid = 1'b1;
        i = ii;
        j = jj;
        tick();
        in_valid = 1'b0;
        i = 1'b0;
        j = 1'b0;
        g = sb.pop_front();
        check("sig", 16'(signature), 16'(g.sig));
        check("cnt", 16'(count), 16'(g.cnt));
        check("done", 16'(done), 16'(g.dn));
    endtask

    task automatic golden_tail(input string tag);
        check({tag, "_sig"}, 16'(signature), 16'hE3);
        check({tag, "_pass"}, 16'(pass), 16'd1);
        check({tag, "_busy"}, 16'(busy), 16'd0);
        check({tag, "_cnt"}, 16'(count), 16'd8);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; seed = 8'h00;
        in_valid = 1'b0; i = 1'b0; j = 1'b0;
        m_sig = 8'h00; m_cnt = 8'd0;

        do_reset();
        check("rst_sig", 16'(signature), 16'd0);
        check("rst_cnt", 16'(count), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_pass", 16'(pass), 16'd0);

        // start with in_valid in IDLE: sample must not be folded
        in_valid = 1'b1; i = 1'b1; j = 1'b1;
        begin_session(8'h00);
        in_valid = 1'b0; i = 1'b0; j = 1'b0;

        // golden run
        for (int k = 0; k < 8; k++) begin
            send(1'b0, 1'b1);
            check("gold_step", 16'(signature), 16'(golden_steps[k]));
        end
        golden_tail("gold");

        // DONE holds and ignores valid samples
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; j = 1'b1;
            tick();
            in_valid = 1'b0; j = 1'b0;
            check("hold_cnt", 16'(count), 16'd8);
            check("hold_sig", 16'(signature), 16'hE3);
            check("hold_done", 16'(done), 16'd1);
        end

        // back-to-back session from DONE, gapped, with a stray start
        begin_session(8'h00);
        for (int k = 0; k < 4; k++) send(1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                start = 1'b1;
                seed  = 8'hFF;
            end
            tick();
            start = 1'b0;
            check("gap_sig", 16'(signature), 16'h1E);
            check("gap_cnt", 16'(count), 16'd4);
            check("gap_busy", 16'(busy), 16'd1);
        end
        for (int k = 0; k < 4; k++) send(1'b0, 1'b1);
        golden_tail("gap");

        // fault run
        begin_session(8'h00);
        for (int k = 0; k < 7; k++) send(1'b0, 1'b1);
        send(1'b0, 1'b0);
        check("fault_sig", 16'(signature), 16'hE1);
        check("fault_pass", 16'(pass), 16'd0);

        // reset mid-session, asserted alongside a valid sample and start
        begin_session(8'h00);
        for (int k = 0; k < 5; k++) send(1'b0, 1'b1);
        in_valid = 1'b1; j = 1'b1; start = 1'b1;
        do_reset();
        in_valid = 1'b0; j = 1'b0; start = 1'b0;
        check("mrst_sig", 16'(signature), 16'd0);
        check("mrst_cnt", 16'(count), 16'd0);
        check("mrst_busy", 16'(busy), 16'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mrst_nodone", 16'(done), 16'd0);
        end
        begin_session(8'h00);
        for (int k = 0; k < 8; k++) send(1'b0, 1'b1);
        golden_tail("after_rst");

        // non-zero seed cross-checked against the bench model
        begin_session(8'hA5);
        for (int k = 0; k < 8; k++) send(1'(k), 1'(k >> 1));
        check("seed_pass", 16'(pass), 16'(m_sig == 8'hE3));

        check("sb_empty", 16'(sb.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
